// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a small byte FIFO.
// Register window (cpu_address[3:2]): 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved.
// Frames are 8N1, LSB first. Defining UART_TX_PARITY_EN inserts an even-parity
// bit between the data bits and the stop bit, and STATUS bit8 reads 1.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int DIV_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        write_enable,
    output logic [31:0] cout,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_empty_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(CLKS_PER_BIT);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [DIV_WIDTH-1:0] baud_div_q, baud_div_d;
    logic [DIV_WIDTH-1:0] frame_div_q, frame_div_d;
    logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 irq_q, irq_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic [1:0]  reg_sel;
    logic        wr_txdata, wr_status, wr_baud;
    logic        fifo_full, fifo_empty;
    logic        pop, push;
    logic [7:0]  head;
    logic        bit_done;
    logic [3:0]  count_sat;
    logic [31:0] status;
    logic        unused_bits;

    assign reg_sel     = cpu_address[3:2];
    assign wr_txdata   = write_enable && (reg_sel == 2'd0);
    assign wr_status   = write_enable && (reg_sel == 2'd1);
    assign wr_baud     = write_enable && (reg_sel == 2'd2);
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    // Head is read asynchronously so the pop and the start bit share one edge.
    assign head        = fifo_mem[rd_ptr_q];
    assign bit_done    = (baud_cnt_q == '0);
    assign count_sat   = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
    assign unused_bits = ^{cpu_address[31:4], cpu_address[1:0], cpu_data};

    assign tx           = tx_q;
    assign tx_busy      = (state_q != S_IDLE) || !fifo_empty;
    assign tx_empty_irq = irq_q;

    // Next-state logic: frame sequencing, FIFO bookkeeping and register writes.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_cnt_d  = baud_cnt_q;
        frame_div_d = frame_div_q;
        tx_d        = tx_q;
        irq_d       = 1'b0;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d    = S_DATA;
                    tx_d       = shift_q[0];
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = frame_div_q - DIV_ONE;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = frame_div_q - DIV_ONE;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    baud_cnt_d = frame_div_q - DIV_ONE;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        irq_d   = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Starting a frame: the divider is sampled here, so later BAUDDIV
        // writes only take effect at the next frame.
        if (pop) begin
            state_d     = S_START;
            shift_d     = head;
            frame_div_d = baud_div_q;
            baud_cnt_d  = baud_div_q - DIV_ONE;
            tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^head;
`endif
        end

        // A pop in the same cycle frees a slot, so a push at full succeeds.
        push      = wr_txdata && (!fifo_full || pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        overflow_d = overflow_q;
        if (wr_txdata && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (wr_status && cpu_data[3]) begin
            overflow_d = 1'b0;
        end

        baud_div_d = baud_div_q;
        if (wr_baud) begin
            baud_div_d = (cpu_data[DIV_WIDTH-1:0] == '0) ? DIV_ONE : cpu_data[DIV_WIDTH-1:0];
        end
    end

    // FIFO storage: no reset, contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cpu_data[7:0];
        end
    end

    // State register; reset aborts any frame in progress and drops the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            baud_div_q  <= DIV_RST;
            frame_div_q <= DIV_RST;
            baud_cnt_q  <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            irq_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            baud_div_q  <= baud_div_d;
            frame_div_q <= frame_div_d;
            baud_cnt_q  <= baud_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            irq_q       <= irq_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Register read mux for CPU loads.
    always_comb begin
        status       = 32'h0;
        status[0]    = fifo_full;
        status[1]    = fifo_empty;
        status[2]    = tx_busy;
        status[3]    = overflow_q;
        status[7:4]  = count_sat;
`ifdef UART_TX_PARITY_EN
        status[8]    = 1'b1;
`endif
        cout = 32'h0;
        case (reg_sel)
            2'd1:    cout = status;
            2'd2:    cout = 32'(baud_div_q);
            default: cout = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: register vectors from a table, then directed
// frame sequences checked cycle by cycle against hand-computed bit patterns.
module tb_uart_tx_fifo;
    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_ST  = 32'h4;
    localparam logic [31:0] A_BD  = 32'h8;
    localparam logic [31:0] A_RSV = 32'hC;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PAR   = 32'h100;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PAR   = 32'h0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address;
    logic [31:0] cpu_data;
    logic        write_enable;
    logic [31:0] cout;
    logic        tx;
    logic        tx_busy;
    logic        tx_empty_irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_address  (cpu_address),
        .cpu_data     (cpu_data),
        .write_enable (write_enable),
        .cout         (cout),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_empty_irq (tx_empty_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        cpu_address  = addr;
        cpu_data     = data;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        cpu_data     = 32'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] val);
        write_enable = 1'b0;
        cpu_address  = addr;
        #1;
        val = cout;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int bi);
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
        if (bi == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Checks tx from cycle 'skip' of a frame that started at the previous edge;
    // one comparison per bit (matching samples vs. samples taken).
    task automatic frame_check(input logic [7:0] b, input int d, input int skip, input string tag);
        int match_cnt;
        int samp_cnt;
        int irq_cnt;
        match_cnt = 0;
        samp_cnt  = 0;
        irq_cnt   = 0;
        for (int k = skip; k < NBITS * d; k++) begin
            samp_cnt++;
            if (tx === exp_bit(b, k / d)) match_cnt++;
            if (tx_empty_irq !== 1'b0) irq_cnt++;
            if ((k % d) == d - 1) begin
                check($sformatf("%s bit%0d", tag, k / d), 32'(match_cnt), 32'(samp_cnt));
                match_cnt = 0;
                samp_cnt  = 0;
            end
            tick();
        end
        check({tag, " irq_in_frame"}, 32'(irq_cnt), 32'd0);
        $display("frame %s byte=0x%02h div=%0d skip=%0d checked", tag, b, d, skip);
    endtask

    // Called at the edge where the last stop bit ends.
    task automatic finish_frame(input string tag);
        check1({tag, " irq_pulse"}, tx_empty_irq, 1'b1);
        tick();
        check1({tag, " irq_clear"}, tx_empty_irq, 1'b0);
        check1({tag, " tx_idle"}, tx, 1'b1);
        check1({tag, " busy_clear"}, tx_busy, 1'b0);
    endtask

    initial begin
        vec_t        vecs [14];
        logic [31:0] r;
        int          s;
        int          bad_idle;

        vecs[0]  = '{1'b0, A_ST, 32'h0, 32'h2 | PAR};
        vecs[1]  = '{1'b0, A_BD, 32'h0, 32'd868};
        vecs[2]  = '{1'b0, A_TX, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, A_RSV, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, A_BD, 32'h1234, 32'h0};
        vecs[5]  = '{1'b0, A_BD, 32'h0, 32'h1234};
        vecs[6]  = '{1'b1, A_BD, 32'hABCD0007, 32'h0};
        vecs[7]  = '{1'b0, 32'h10000008, 32'h0, 32'h7};
        vecs[8]  = '{1'b1, A_RSV, 32'hFFFFFFFF, 32'h0};
        vecs[9]  = '{1'b0, A_BD, 32'h0, 32'h7};
        vecs[10] = '{1'b1, A_ST, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{1'b0, A_ST, 32'h0, 32'h2 | PAR};
        vecs[12] = '{1'b1, A_BD, 32'h00010000, 32'h0};
        vecs[13] = '{1'b0, A_BD, 32'h0, 32'h1};

        reset        = 1'b0;
        write_enable = 1'b0;
        cpu_address  = 32'h0;
        cpu_data     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset tx", tx, 1'b1);
        check1("reset busy", tx_busy, 1'b0);
        check1("reset irq", tx_empty_irq, 1'b0);
        reset = 1'b1;
        tick();

        // Register access vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
                $display("vec %0d: write addr=0x%08h data=0x%08h", i, vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, r);
                check($sformatf("vec%0d read 0x%08h", i, vecs[i].addr), r, vecs[i].exp);
                $display("vec %0d: read addr=0x%08h got=0x%08h exp=0x%08h", i, vecs[i].addr, r, vecs[i].exp);
                tick();
            end
        end

        // Single byte, div 4: count=1 after the push edge, tx falls one edge later
        wr(A_BD, 32'd4);
        wr(A_TX, 32'hA5);
        check1("single tx_before_start", tx, 1'b1);
        rd(A_ST, r);
        check("single status_after_push", r, 32'h14 | PAR);
        tick();
        check1("single busy", tx_busy, 1'b1);
        frame_check(8'hA5, 4, 0, "single");
        finish_frame("single");

        // Back-to-back frames with no idle gap, div 2
        wr(A_BD, 32'd2);
        wr(A_TX, 32'h00);
        wr(A_TX, 32'hFF);
        frame_check(8'h00, 2, 0, "b2b0");
        frame_check(8'hFF, 2, 0, "b2b1");
        finish_frame("b2b");

        // Divider 0 is stored as 1: one-cycle bits
        wr(A_BD, 32'd0);
        rd(A_BD, r);
        check("div0 readback", r, 32'd1);
        wr(A_TX, 32'h5A);
        tick();
        frame_check(8'h5A, 1, 0, "div1");
        finish_frame("div1");

        // Divider change mid-frame applies from the next frame
        wr(A_BD, 32'd4);
        wr(A_TX, 32'h3C);
        s = cyc + 1;
        tick();
        wr(A_BD, 32'd8);
        wr(A_TX, 32'h81);
        frame_check(8'h3C, 4, cyc - s, "div4");
        frame_check(8'h81, 8, 0, "div8");
        finish_frame("divchg");

        // Overflow: 10 writes, the 10th is dropped
        wr(A_BD, 32'd100);
        for (int i = 0; i < 10; i++) begin
            wr(A_TX, 32'h10 + 32'(i));
            if (i == 0) s = cyc + 1;
        end
        rd(A_ST, r);
        check("ovf status_full", r, 32'h8D | PAR);
        wr(A_ST, 32'h8);
        rd(A_ST, r);
        check("ovf status_cleared", r, 32'h85 | PAR);
        frame_check(8'h10, 100, cyc - s, "ovf10");
        for (int i = 1; i <= 8; i++) begin
            frame_check(8'h10 + 8'(i), 100, 0, $sformatf("ovf%02h", 8'h10 + 8'(i)));
        end
        finish_frame("ovf");
        rd(A_ST, r);
        check("ovf status_drained", r, 32'h2 | PAR);

`ifdef UART_TX_PARITY_EN
        // Even parity bit between data and stop
        wr(A_BD, 32'd2);
        wr(A_TX, 32'h07);
        tick();
        frame_check(8'h07, 2, 0, "par07");
        finish_frame("par07");
        wr(A_TX, 32'h03);
        tick();
        frame_check(8'h03, 2, 0, "par03");
        finish_frame("par03");
`endif

        // Reset mid-frame: line released at once, FIFO contents lost
        wr(A_BD, 32'd4);
        wr(A_TX, 32'hC3);
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'h11);
        repeat (6) tick();
        reset = 1'b0;
        #1;
        check1("midreset tx", tx, 1'b1);
        check1("midreset busy", tx_busy, 1'b0);
        rd(A_ST, r);
        check("midreset status", r, 32'h2 | PAR);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        rd(A_ST, r);
        check("postreset status", r, 32'h2 | PAR);
        rd(A_BD, r);
        check("postreset baud", r, 32'd868);
        check1("postreset busy", tx_busy, 1'b0);
        bad_idle = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || tx_empty_irq !== 1'b0) bad_idle++;
            tick();
        end
        check("postreset quiet_cycles", 32'(bad_idle), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
